// File: rtl/pulse_shaping_fir_mac.sv
// pulse_shaping_fir_mac
// ---------------------
// Time-multiplexed pulse-shaping FIR for one rail (I or Q) of the QAM-16
// transmitter. A single multiply-accumulate unit walks every tap for each
// accepted sample. The sum is then rounded half-up, arithmetically shifted
// and saturated back to the sample width. Coefficients are signed
// Q1.(COEF_W-1) and can be loaded at run time.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   flush      : clears the delay line and aborts any computation in flight
//   in_valid   : in_data carries a sample
//   in_ready   : a sample can be accepted this cycle
//   in_data    : signed input sample (DATA_W)
//   coef_we    : coefficient write strobe (honoured only while idle)
//   coef_addr  : tap index to write
//   coef_data  : signed coefficient value (COEF_W)
//   out_valid  : one-cycle pulse marking a new out_data
//   out_data   : signed filtered sample, held until the next result
module pulse_shaping_fir_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NTAPS     = 16,
  parameter int OUT_SHIFT = COEF_W - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data
);

  localparam int AW    = $clog2(NTAPS);
  localparam int ACC_W = DATA_W + COEF_W + AW;
  localparam int PRD_W = DATA_W + COEF_W;

  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

  // The rounding and clamping arithmetic uses one guard bit above the
  // accumulator, so adding the half-LSB term can never wrap.
  localparam logic signed [ACC_W:0] RND =
      (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0))
                      : '0;
  localparam logic signed [ACC_W:0] SAT_MAX =
      (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  localparam logic signed [DATA_W-1:0] OUT_MAX = SAT_MAX[DATA_W-1:0];
  localparam logic signed [DATA_W-1:0] OUT_MIN = SAT_MIN[DATA_W-1:0];

  typedef enum logic {
    S_IDLE,
    S_MAC
  } state_t;

  state_t                    state;
  logic [AW-1:0]             idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  x_q [NTAPS];
  logic signed [COEF_W-1:0]  c_q [NTAPS];

  logic signed [PRD_W-1:0]   prod;
  logic signed [ACC_W-1:0]   y;
  logic signed [ACC_W:0]     y_rnd;
  logic signed [ACC_W:0]     r;
  logic signed [DATA_W-1:0]  y_sat;
  logic                      coef_addr_ok;

  assign in_ready = (state == S_IDLE) && !flush;

  // With a power-of-two tap count every address is in range. The
  // widened compare keeps the check correct for other tap counts.
  assign coef_addr_ok = ({1'b0, coef_addr} < (AW+1)'(NTAPS));

  // NOTE: every signal written here gets a value on every path,
  // so no latches are inferred.
  always_comb begin
    prod  = x_q[idx] * c_q[idx];
    y     = acc + ACC_W'(prod);
    y_rnd = (ACC_W+1)'(y) + RND;
    r     = y_rnd >>> OUT_SHIFT;
    if (r > SAT_MAX) begin
      y_sat = OUT_MAX;
    end else if (r < SAT_MIN) begin
      y_sat = OUT_MIN;
    end else begin
      y_sat = r[DATA_W-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // read in this block sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      // NOTE: the delay line and the coefficient bank are register arrays,
      // not RAM. Both start at zero so that the first output after reset is
      // defined.
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        // Abort without a result. Coefficients and out_data are kept.
        state <= S_IDLE;
        idx   <= '0;
        acc   <= '0;
        for (int k = 0; k < NTAPS; k++) begin
          x_q[k] <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            // A write in the same cycle as an accept is used by that
            // sample, because the MAC starts reading coefficients on the
            // next cycle.
            if (coef_we && coef_addr_ok) begin
              c_q[coef_addr] <= coef_data;
            end
            if (in_valid) begin
              for (int k = NTAPS - 1; k > 0; k--) begin
                x_q[k] <= x_q[k-1];
              end
              x_q[0] <= in_data;
              acc    <= '0;
              idx    <= '0;
              state  <= S_MAC;
            end
          end
          S_MAC: begin
            if (idx == LAST_IDX) begin
              out_data  <= y_sat;
              out_valid <= 1'b1;
              acc       <= '0;
              idx       <= '0;
              state     <= S_IDLE;
            end else begin
              acc <= y;
              idx <= idx + AW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_shaping_fir_mac.sv
// Testbench for pulse_shaping_fir_mac (16 taps, 16-bit data and
// coefficients). A reference model computes every expected result when a
// sample is accepted and pushes it to a scoreboard queue. The output monitor
// pops one entry for each out_valid pulse. It checks the data value and the
// accept-to-output latency. A pulse with nothing queued is a failure.
module tb_pulse_shaping_fir_mac;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 16;
  localparam int AW     = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  pulse_shaping_fir_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_SHIFT(COEF_W - 1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    int edge_no;
  } exp_t;

  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mx [NTAPS];
  int   mc [NTAPS];
  exp_t sb [$];
  exp_t mon_e;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: full-precision dot product, round half up, shift, clamp.
  function automatic int model_out();
    longint y = 0;
    for (int k = 0; k < NTAPS; k++) y += longint'(mx[k]) * longint'(mc[k]);
    y = (y + (longint'(1) <<< (COEF_W - 2))) >>> (COEF_W - 1);
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", int'($signed(out_data)), mon_e.val);
        check("latency", edge_cnt - mon_e.edge_no, NTAPS);
      end
    end
  end

  // Call at a falling edge while idle.
  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = COEF_W'(data);
    @(posedge clk);
    if (addr < NTAPS) mc[addr] = int'($signed(COEF_W'(data)));
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offers a sample, waits for the accept edge and updates the model's
  // delay line. Returns at the falling edge after the accept.
  task automatic offer(input int d, output bit ok);
    int w = 0;
    in_data  = DATA_W'(d);
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = int'($signed(DATA_W'(d)));
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // Offers a sample and queues its expected result. The expected value is
  // either a fixed constant or the model result. Returns at the first
  // falling edge where in_ready is high again.
  task automatic send(input int d, input bit use_const, input int cval);
    bit   ok;
    int   cnt = 0;
    exp_t e;
    offer(d, ok);
    if (!ok) return;
    e.val     = use_const ? cval : model_out();
    e.edge_no = edge_cnt;
    sb.push_back(e);
    while (!in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_low_cycles", cnt, NTAPS);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected it to");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int k = 0; k < NTAPS; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_in_ready", int'(in_ready), 1);

    // Impulse response through c[k] = 256*k, offered back-to-back.
    for (int k = 0; k < NTAPS; k++) write_coef(k, 256 * k);
    send('h4000, 1, 0);
    for (int n = 1; n < NTAPS; n++) send(0, 1, 128 * n);

    // Rounding at the half-LSB boundary.
    for (int k = 0; k < NTAPS; k++) write_coef(k, (k == 0) ? 1 : 0);
    send('h4000, 1, 1);
    send('h3FFF, 1, 0);
    write_coef(0, -1);
    send('h4000, 1, 0);

    // A coefficient write during MAC must be dropped. The model keeps the
    // old c[0], so the current result and later results expose a taken write.
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1000 * k - 7000);
    fork
      send('h1234, 0, 0);
      begin
        repeat (4) @(negedge clk);
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'h7FFF;
        @(negedge clk);
        coef_we = 1'b0;
      end
    join
    send('hE000, 0, 0);
    send('h7000, 0, 0);
    send('h8001, 0, 0);

    // Flush on the 5th MAC cycle with in_valid high. The sample offered
    // during the flush must not be taken.
    offer('h5555, ok);
    repeat (4) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    #1;
    check("flush_in_ready", int'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("post_flush_in_ready", int'(in_ready), 1);
    for (int k = 0; k < NTAPS; k++) mx[k] = 0;
    @(negedge clk);
    send('h4000, 0, 0);
    send('h2000, 0, 0);
    send(0, 0, 0);

    // Saturation in both directions.
    for (int k = 0; k < NTAPS; k++) write_coef(k, 'h7FFF);
    for (int n = 0; n < NTAPS; n++) send('h7FFF, n == NTAPS - 1, 32767);
    for (int n = 0; n < NTAPS; n++) send('h8000, n == NTAPS - 1, -32768);

    // Reset in the middle of a computation drops it.
    offer('h3000, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_data", int'(out_data), 0);
    check("midreset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    for (int k = 0; k < NTAPS; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
    repeat (25) @(negedge clk);
    check("post_reset_out_data_held", int'(out_data), 0);
    // Coefficients were cleared by reset, so any sample filters to zero.
    send('h7FFF, 1, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
